// File: rtl/multiplication.sv
// rtl/multiplication.sv - sequential shift-and-add fixed-point by small-integer multiplier
module multiplication #(
    parameter int A_W  = 20,
    parameter int B_W  = 3,
    parameter int FRAC = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [A_W-1:0]          in_data_1,
    input  logic [B_W-1:0]          in_data_2,
    output logic                    out_valid,
    output logic [A_W+B_W-1:0]      out_data,
    output logic [A_W-FRAC+B_W-1:0] out_int
);

    localparam int P_W = A_W + B_W;
    localparam int I_W = A_W - FRAC + B_W;
    localparam logic [P_W-1:0] HALF = P_W'(1) << (FRAC - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MULT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [P_W-1:0]   a_q, a_d;
    logic [B_W-1:0]   b_q, b_d;
    logic [P_W-1:0]   acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [P_W-1:0]   out_data_q, out_data_d;
    logic [I_W-1:0]   out_int_q, out_int_d;

    // Accumulator after the current multiplier bit, and its round-half-up form.
    // The shifted multiplicand is product-wide, so neither sum can overflow.
    logic [P_W-1:0]   partial;
    logic [P_W-1:0]   acc_sum;
    logic [P_W-1:0]   rounded;
    logic [B_W-1:0]   b_shifted;

    assign partial   = b_q[0] ? a_q : '0;
    assign acc_sum   = acc_q + partial;
    assign rounded   = acc_sum + HALF;
    assign b_shifted = b_q >> 1;

    // Next-state logic: capture operands, iterate LSB-first, publish on exit.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_int_d   = out_int_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = {{B_W{1'b0}}, in_data_1};
                    b_d     = in_data_2;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    a_d = {{B_W{1'b0}}, in_data_1};
                    b_d = in_data_2;
                end else begin
                    acc_d   = '0;
                    state_d = MULT;
                end
            end
            MULT: begin
                acc_d = acc_sum;
                a_d   = a_q << 1;
                b_d   = b_shifted;
                // Results are registered on the exit edge so they line up with DONE.
                if (b_shifted == '0) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_sum;
                    out_int_d   = rounded[P_W-1:FRAC];
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_int_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_int_q   <= out_int_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_int   = out_int_q;

endmodule

// File: tb/tb_multiplication.sv
// tb/tb_multiplication.sv - randomized and directed bench for multiplication
module tb_multiplication;

    localparam int A_W  = 20;
    localparam int B_W  = 3;
    localparam int FRAC = 10;
    localparam int P_W  = A_W + B_W;
    localparam int I_W  = A_W - FRAC + B_W;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [A_W-1:0] in_data_1;
    logic [B_W-1:0] in_data_2;
    logic           out_valid;
    logic [P_W-1:0] out_data;
    logic [I_W-1:0] out_int;

    int checks = 0;
    int errors = 0;

    multiplication #(.A_W(A_W), .B_W(B_W), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data_1 (in_data_1),
        .in_data_2 (in_data_2),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_int   (out_int)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on the operand values.
    function automatic logic [P_W-1:0] model_prod(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return P_W'(p);
    endfunction

    function automatic logic [I_W-1:0] model_int(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        longint p;
        p = longint'(a) * longint'(b);
        return I_W'((p + (longint'(1) << (FRAC - 1))) / (longint'(1) << FRAC));
    endfunction

    // Negedges from dropping in_valid until out_valid: one load edge plus k multiply cycles.
    function automatic int model_lat(input logic [B_W-1:0] b);
        int k;
        k = (b == 0) ? 1 : $clog2(int'(b) + 1);
        return k + 1;
    endfunction

    // Drives one transaction starting at a negedge; in_valid held 'hold' cycles,
    // only the final pair being the real operands. Returns results and the
    // state one cycle after the strobe.
    task automatic run_txn(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input int hold,
                           output logic [P_W-1:0] d, output logic [I_W-1:0] i, output int lat,
                           output logic v_after, output logic [P_W-1:0] d_after);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            if (h == hold - 1) begin
                in_data_1 = a;
                in_data_2 = b;
            end else begin
                in_data_1 = A_W'($urandom);
                in_data_2 = B_W'($urandom);
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        in_data_1 = A_W'($urandom);
        in_data_2 = B_W'($urandom);
        lat = -1;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        d = out_data;
        i = out_int;
        @(negedge clk);
        v_after = out_valid;
        d_after = out_data;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data_1 = '0;
        in_data_2 = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_int !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b data=%h int=%0d, want 0/0/0", out_valid, out_data, out_int);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_idle: got valid=%b data=%h, want 0/0", out_valid, out_data);
        end
    endtask

    task automatic test_directed();
        logic [A_W-1:0] ta [6] = '{20'h00C00, 20'h00200, 20'h001FF, 20'hFFFFF, 20'hFFFFF, 20'h00D55};
        logic [B_W-1:0] tb [6] = '{3'd5, 3'd3, 3'd1, 3'd0, 3'd7, 3'd3};
        logic [P_W-1:0] td [6] = '{23'h003C00, 23'h000600, 23'h0001FF, 23'h000000, 23'h6FFFF9, 23'h0027FF};
        logic [I_W-1:0] ti [6] = '{13'd15, 13'd2, 13'd0, 13'd0, 13'd7168, 13'd10};
        int             tl [6] = '{4, 3, 2, 2, 4, 3};
        logic [P_W-1:0] d, d_after;
        logic [I_W-1:0] i;
        int             lat;
        logic           v_after;
        for (int t = 0; t < 6; t++) begin
            run_txn(ta[t], tb[t], 1, d, i, lat, v_after, d_after);
            checks++;
            if (d !== td[t]) begin
                errors++;
                $display("FAIL directed_data[%0d]: got %h, want %h", t, d, td[t]);
            end
            checks++;
            if (i !== ti[t]) begin
                errors++;
                $display("FAIL directed_int[%0d]: got %0d, want %0d", t, i, ti[t]);
            end
            checks++;
            if (lat !== tl[t]) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d, want %0d", t, lat, tl[t]);
            end
            checks++;
            if (v_after !== 1'b0 || d_after !== td[t]) begin
                errors++;
                $display("FAIL directed_hold[%0d]: got valid=%b data=%h, want 0/%h", t, v_after, d_after, td[t]);
            end
        end
    endtask

    task automatic test_round_trip();
        logic [P_W-1:0] d, d_after;
        logic [I_W-1:0] i;
        int             lat;
        logic           v_after;
        logic [A_W-1:0] q;
        int             bad = 0;
        for (int dvd = 0; dvd < 1024; dvd++) begin
            for (int dvs = 1; dvs <= 7; dvs++) begin
                q = A_W'((dvd << FRAC) / dvs);
                run_txn(q, B_W'(dvs), 1, d, i, lat, v_after, d_after);
                checks++;
                if (i !== I_W'(dvd)) begin
                    errors++;
                    if (bad < 10) $display("FAIL round_trip d=%0d s=%0d: got %0d, want %0d", dvd, dvs, i, dvd);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_load_hold();
        logic [P_W-1:0] d, d_after;
        logic [I_W-1:0] i;
        int             lat;
        logic           v_after;
        run_txn(20'h00400, 3'd6, 4, d, i, lat, v_after, d_after);
        checks++;
        if (d !== 23'h001800 || i !== 13'd6) begin
            errors++;
            $display("FAIL load_hold: got data=%h int=%0d, want 001800/6", d, i);
        end
        checks++;
        if (lat !== model_lat(3'd6)) begin
            errors++;
            $display("FAIL load_hold_latency: got %0d, want %0d", lat, model_lat(3'd6));
        end
    endtask

    task automatic test_ignore_during_mult();
        int             seen = 0;
        logic [P_W-1:0] d = '0;
        in_valid  = 1'b1;
        in_data_1 = 20'hFFFFF;
        in_data_2 = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data_1 = 20'h00001;
        in_data_2 = 3'd1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid) begin
                seen++;
                d = out_data;
            end
        end
        checks++;
        if (seen !== 1) begin
            errors++;
            $display("FAIL ignore_count: got %0d strobes, want 1", seen);
        end
        checks++;
        if (d !== 23'h6FFFF9) begin
            errors++;
            $display("FAIL ignore_data: got %h, want 6ffff9", d);
        end
    endtask

    task automatic test_async_reset();
        logic [P_W-1:0] d, d_after;
        logic [I_W-1:0] i;
        int             lat;
        logic           v_after;
        int             seen = 0;
        run_txn(20'h00C00, 3'd5, 1, d, i, lat, v_after, d_after);
        in_valid  = 1'b1;
        in_data_1 = 20'hFFFFF;
        in_data_2 = 3'd7;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_int !== '0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b data=%h int=%0d, want 0/0/0", out_valid, out_data, out_int);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL async_reset_abort: got %0d strobes, want 0", seen);
        end
        run_txn(20'h00800, 3'd2, 1, d, i, lat, v_after, d_after);
        checks++;
        if (i !== 13'd4 || d !== 23'h001000) begin
            errors++;
            $display("FAIL after_reset: got data=%h int=%0d, want 001000/4", d, i);
        end
    endtask

    // Consecutive run_txn calls start in the cycle right after the strobe.
    task automatic test_back_to_back_random();
        logic [P_W-1:0] d, d_after;
        logic [I_W-1:0] i;
        int             lat;
        logic           v_after;
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        for (int t = 0; t < 60; t++) begin
            a = A_W'($urandom);
            b = B_W'($urandom);
            run_txn(a, b, $urandom_range(1, 3), d, i, lat, v_after, d_after);
            checks++;
            if (d !== model_prod(a, b) || i !== model_int(a, b)) begin
                errors++;
                $display("FAIL random[%0d] a=%h b=%0d: got %h/%0d, want %h/%0d", t, a, b, d, i, model_prod(a, b), model_int(a, b));
            end
            checks++;
            if (lat !== model_lat(b) || v_after !== 1'b0) begin
                errors++;
                $display("FAIL random_timing[%0d]: got lat=%0d after=%b, want %0d/0", t, lat, v_after, model_lat(b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_load_hold();
        test_ignore_during_mult();
        test_async_reset();
        test_back_to_back_random();
        test_round_trip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
